// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with registered sync, data-enable and RGB gating.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 1,
  parameter int CLK_DIV  = 2,
  parameter int CTR_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*COLOR_W-1:0] rgb,
  output logic [CTR_W-1:0]     oCtrH,
  output logic [CTR_W-1:0]     oCtrV,
  output logic [COLOR_W-1:0]   RED,
  output logic [COLOR_W-1:0]   GREEN,
  output logic [COLOR_W-1:0]   BLUE,
  output logic                 HS,
  output logic                 VS,
  output logic                 oDE,
  output logic                 oPixTick,
  output logic                 oLineStart,
  output logic                 oFrameStart
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CTR_W-1:0] H_LAST = CTR_W'(H_TOTAL - 1);
  localparam logic [CTR_W-1:0] V_LAST = CTR_W'(V_TOTAL - 1);
  localparam logic [CTR_W-1:0] H_VIS  = CTR_W'(H_ACTIVE);
  localparam logic [CTR_W-1:0] V_VIS  = CTR_W'(V_ACTIVE);
  localparam logic [CTR_W-1:0] HS_BEG = CTR_W'(H_ACTIVE + H_FP);
  localparam logic [CTR_W-1:0] HS_END = CTR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CTR_W-1:0] VS_BEG = CTR_W'(V_ACTIVE + V_FP);
  localparam logic [CTR_W-1:0] VS_END = CTR_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]     div_q, div_d;
  logic [CTR_W-1:0]     h_q, h_d, v_q, v_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic                 tick, h_wrap, v_wrap, active, hs_on, vs_on;

  always_comb begin
    tick   = div_q == DIV_LAST;
    h_wrap = tick && h_q == H_LAST;
    v_wrap = h_wrap && v_q == V_LAST;
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = !tick ? h_q : h_wrap ? '0 : h_q + 1'b1;
    v_d    = !h_wrap ? v_q : v_wrap ? '0 : v_q + 1'b1;
    active = h_q < H_VIS && v_q < V_VIS;
    hs_on  = h_q >= HS_BEG && h_q < HS_END;
    vs_on  = v_q >= VS_BEG && v_q < VS_END;
    hs_d   = hs_on ? HS_POL : ~HS_POL;
    vs_d   = vs_on ? VS_POL : ~VS_POL;
    de_d   = active;
    rgb_d  = active ? rgb : '0;
    ls_d   = h_wrap;
    fs_d   = v_wrap;
  end

  // Decode uses the pre-advance counters, so every output lags the counters by one clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign oCtrH              = h_q;
  assign oCtrV              = v_q;
  assign {RED, GREEN, BLUE} = rgb_q;
  assign HS                 = hs_q;
  assign VS                 = vs_q;
  assign oDE                = de_q;
  assign oPixTick           = tick;
  assign oLineStart         = ls_q;
  assign oFrameStart        = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two generator instances (small active-low CLK_DIV=3 raster, and an active-high CLK_DIV=1
// raster) checked cycle by cycle against an arithmetic model derived from the elapsed clock count.
module tb_vga_timing_gen;
  localparam int AHA = 20, AHF = 3, AHS = 5, AHB = 4, AVA = 10, AVF = 2, AVS = 2, AVB = 3, ADV = 3;
  localparam int BHA = 4, BHF = 1, BHS = 2, BHB = 1, BVA = 3, BVF = 1, BVS = 1, BVB = 1, BDV = 1;
  localparam int A_FRAME = (AHA + AHF + AHS + AHB) * (AVA + AVF + AVS + AVB) * ADV;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic hs, vs, de, ls, fs, tick;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [5:0]  rgb_a = '0;
  logic [11:0] rgb_b = '0;
  logic [5:0]  ctrh_a, ctrv_a;
  logic [3:0]  ctrh_b, ctrv_b;
  logic [1:0]  r_a, g_a, b_a;
  logic [3:0]  r_b, g_b, b_b;
  logic hs_a, vs_a, de_a, pt_a, ls_a, fs_a;
  logic hs_b, vs_b, de_b, pt_b, ls_b, fs_b;
  int checks = 0, errors = 0, k = 0;
  bit rnd = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB), .V_ACTIVE(AVA), .V_FP(AVF),
    .V_SYNC(AVS), .V_BP(AVB), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(2), .CLK_DIV(ADV), .CTR_W(6)) dut_a (
    .clk(clk), .rst(rst), .rgb(rgb_a), .oCtrH(ctrh_a), .oCtrV(ctrv_a), .RED(r_a), .GREEN(g_a), .BLUE(b_a),
    .HS(hs_a), .VS(vs_a), .oDE(de_a), .oPixTick(pt_a), .oLineStart(ls_a), .oFrameStart(fs_a));

  vga_timing_gen #(.H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB), .V_ACTIVE(BVA), .V_FP(BVF),
    .V_SYNC(BVS), .V_BP(BVB), .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .CLK_DIV(BDV), .CTR_W(4)) dut_b (
    .clk(clk), .rst(rst), .rgb(rgb_b), .oCtrH(ctrh_b), .oCtrV(ctrv_b), .RED(r_b), .GREEN(g_b), .BLUE(b_b),
    .HS(hs_b), .VS(vs_b), .oDE(de_b), .oPixTick(pt_b), .oLineStart(ls_b), .oFrameStart(fs_b));

  // After k edges out of reset, k/div pixels have elapsed; registered outputs describe the pixel at edge k-1.
  function automatic exp_t ref_at(input int kk, input int ha, hf, hsw, hb, va, vf, vsw, vb, dv,
                                  input bit hp, vp);
    exp_t r;
    int ht, vt, p, q, hq, vq;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p = kk / dv;
    r.h = 16'(p % ht);
    r.v = 16'((p / ht) % vt);
    r.tick = (kk % dv) == dv - 1;
    if (kk == 0) begin
      r.hs = ~hp; r.vs = ~vp; r.de = 1'b0; r.ls = 1'b0; r.fs = 1'b0;
    end else begin
      q = (kk - 1) / dv;
      hq = q % ht;
      vq = (q / ht) % vt;
      r.de = hq < ha && vq < va;
      r.hs = (hq >= ha + hf && hq < ha + hf + hsw) ? hp : ~hp;
      r.vs = (vq >= va + vf && vq < va + vf + vsw) ? vp : ~vp;
      r.ls = (kk % dv == 0) && (p % ht == 0);
      r.fs = (kk % dv == 0) && (p % (ht * vt) == 0);
    end
    return r;
  endfunction

  task automatic step();
    if (rnd) begin
      rgb_a = 6'($urandom);
      rgb_b = 12'($urandom);
    end
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rnd = 1'b0;
    rgb_a = 6'b110000;
    rgb_b = 12'hF00;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if ({ctrh_a, ctrv_a, ctrh_b, ctrv_b} !== 20'h0) begin
      errors++;
      $display("FAIL reset_counters got %h expected 0", {ctrh_a, ctrv_a, ctrh_b, ctrv_b});
    end
    checks++;
    if ({hs_a, vs_a, de_a, ls_a, fs_a, pt_a} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl_a got %b expected 110000", {hs_a, vs_a, de_a, ls_a, fs_a, pt_a});
    end
    checks++;
    if ({hs_b, vs_b, de_b, ls_b, fs_b, pt_b} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl_b got %b expected 000001", {hs_b, vs_b, de_b, ls_b, fs_b, pt_b});
    end
    checks++;
    if ({r_a, g_a, b_a, r_b, g_b, b_b} !== 18'h0) begin
      errors++;
      $display("FAIL reset_rgb got %h expected 0", {r_a, g_a, b_a, r_b, g_b, b_b});
    end
    @(negedge clk);
    rst = 1'b1;
    k = 0;
  endtask

  task automatic test_raster(input int n);
    exp_t ea, eb;
    logic [23:0] oa, xa;
    logic [25:0] ob, xb;
    for (int i = 0; i < n; i++) begin
      step();
      ea = ref_at(k, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, ADV, 1'b0, 1'b0);
      eb = ref_at(k, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, BDV, 1'b1, 1'b1);
      oa = {ctrh_a, ctrv_a, hs_a, vs_a, de_a, ls_a, fs_a, pt_a, r_a, g_a, b_a};
      xa = {6'(ea.h), 6'(ea.v), ea.hs, ea.vs, ea.de, ea.ls, ea.fs, ea.tick, ea.de ? rgb_a : 6'd0};
      ob = {ctrh_b, ctrv_b, hs_b, vs_b, de_b, ls_b, fs_b, pt_b, r_b, g_b, b_b};
      xb = {4'(eb.h), 4'(eb.v), eb.hs, eb.vs, eb.de, eb.ls, eb.fs, eb.tick, eb.de ? rgb_b : 12'd0};
      checks++;
      if (oa !== xa) begin
        errors++;
        $display("FAIL raster_a k=%0d got %h expected %h", k, oa, xa);
      end
      checks++;
      if (ob !== xb) begin
        errors++;
        $display("FAIL raster_b k=%0d got %h expected %h", k, ob, xb);
      end
    end
  endtask

  task automatic test_colour_gating();
    rnd = 1'b0;
    rgb_a = 6'b111111;
    rgb_b = 12'hFFF;
    test_raster(A_FRAME);
    rgb_a = 6'b110000;
    rgb_b = 12'h5A3;
    test_raster(A_FRAME / 2);
    rnd = 1'b1;
  endtask

  task automatic test_periods();
    int fa_last = -1, fa_span = -1, la_last = -1, la_span = -1, fb_last = -1, fb_span = -1;
    int hs_run = 0, hs_len = -1, vs_run = 0, vs_len = -1, hb_run = 0, hb_len = -1, vb_run = 0, vb_len = -1;
    int lone_fs = 0;
    for (int i = 0; i < 2 * A_FRAME + 300; i++) begin
      step();
      if (fs_a) begin
        if (fa_last >= 0) fa_span = k - fa_last;
        fa_last = k;
        if (!ls_a) lone_fs++;
      end
      if (ls_a) begin
        if (la_last >= 0) la_span = k - la_last;
        la_last = k;
      end
      if (fs_b) begin
        if (fb_last >= 0) fb_span = k - fb_last;
        fb_last = k;
        if (!ls_b) lone_fs++;
      end
      if (!hs_a) hs_run++; else begin if (hs_run > 0) hs_len = hs_run; hs_run = 0; end
      if (!vs_a) vs_run++; else begin if (vs_run > 0) vs_len = vs_run; vs_run = 0; end
      if (hs_b) hb_run++; else begin if (hb_run > 0) hb_len = hb_run; hb_run = 0; end
      if (vs_b) vb_run++; else begin if (vb_run > 0) vb_len = vb_run; vb_run = 0; end
    end
    checks++;
    if (fa_span !== 1632) begin errors++; $display("FAIL frame_period_a got %0d expected 1632", fa_span); end
    checks++;
    if (la_span !== 96) begin errors++; $display("FAIL line_period_a got %0d expected 96", la_span); end
    checks++;
    if (fb_span !== 48) begin errors++; $display("FAIL frame_period_b got %0d expected 48", fb_span); end
    checks++;
    if (hs_len !== 15) begin errors++; $display("FAIL hs_width_a got %0d expected 15", hs_len); end
    checks++;
    if (vs_len !== 192) begin errors++; $display("FAIL vs_width_a got %0d expected 192", vs_len); end
    checks++;
    if (hb_len !== 2) begin errors++; $display("FAIL hs_width_b got %0d expected 2", hb_len); end
    checks++;
    if (vb_len !== 8) begin errors++; $display("FAIL vs_width_b got %0d expected 8", vb_len); end
    checks++;
    if (lone_fs !== 0) begin errors++; $display("FAIL frame_without_line got %0d expected 0", lone_fs); end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(ctrh_a == 6'd15 && ctrv_a == 6'd3) && guard < 2 * A_FRAME) begin
      step();
      guard++;
    end
    checks++;
    if (ctrh_a !== 6'd15) begin
      errors++;
      $display("FAIL mid_reset_reach got %0d expected 15", ctrh_a);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({ctrh_a, ctrv_a, ctrh_b, ctrv_b} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset_counters got %h expected 0", {ctrh_a, ctrv_a, ctrh_b, ctrv_b});
    end
    checks++;
    if ({hs_a, vs_a, de_a, ls_a, fs_a, r_a, g_a, b_a} !== 11'b11000000000) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b expected 11000000000", {hs_a, vs_a, de_a, ls_a, fs_a, r_a, g_a, b_a});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    test_raster(A_FRAME + 100);
  endtask

  initial begin
    test_reset();
    rnd = 1'b1;
    test_raster(2 * A_FRAME + 50);
    test_colour_gating();
    test_periods();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with RGB gating. It is the successor to the fixed 640x480, 3-bit-colour VGA block. Resolution, porch and sync widths, sync polarity, colour depth and clock-to-pixel divide ratio are all parameters. It also adds a data-enable output, line/frame strobes and a pixel-tick output, and sits between the pixel source (framebuffer/pattern logic driven by `oCtrH`/`oCtrV`) and the board VGA pins.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, HS asserted level (0 = active-low)
- `VS_POL`, 0, VS asserted level
- `COLOR_W`, 1, bits per colour channel
- `CLK_DIV`, 2, `clk` cycles per pixel (>=1)
- `CTR_W`, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `rgb`  in  3*COLOR_W  pixel colour {R,G,B}, sampled every `clk`
- `oCtrH`  out  CTR_W  horizontal counter, 0..H_TOTAL-1
- `oCtrV`  out  CTR_W  vertical counter, 0..V_TOTAL-1
- `RED`, `GREEN`, `BLUE`  out  COLOR_W each  gated colour
- `HS`, `VS`  out  1  sync outputs, polarity per parameter
- `oDE`  out  1  high while the registered pixel is in the active area
- `oPixTick`  out  1  one-`clk` pulse; counters advance on this edge
- `oLineStart`  out  1  one-`clk` pulse when `oCtrH` wraps to 0
- `oFrameStart`  out  1  one-`clk` pulse when (`oCtrH`,`oCtrV`) wraps to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is formed the same way (default 525).
- **Divider:** `div` counts 0..CLK_DIV-1. `tick` = (div == CLK_DIV-1). With CLK_DIV=1, `tick` is constantly 1. `oPixTick` = `tick` (combinational from the `div` register).
- **Horizontal counter:** on `tick`, h = (h == H_TOTAL-1) ? 0 : h+1.
- **Vertical counter:** v advances only on a `tick` where h wraps; v = (v == V_TOTAL-1) ? 0 : v+1.
- **`oLineStart`:** registered, high for the single `clk` after an h wrap.
- **`oFrameStart`:** registered, high for the single `clk` after an h wrap coincides with a v wrap.
- **Decode, from the current counters:**
  - active = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs_on = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_on = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
- **Registered outputs, every `clk`:**
  - HS = hs_on ? HS_POL : ~HS_POL; VS follows the same rule with VS_POL.
  - `oDE` = active.
  - {RED,GREEN,BLUE} = active ? `rgb` : 0.
- All arithmetic is unsigned CTR_W. No counter ever exceeds its TOTAL-1.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - div=0; `oCtrH`=0; `oCtrV`=0.
  - RED/GREEN/BLUE=0; `oDE`=0.
  - HS=~HS_POL; VS=~VS_POL.
  - `oLineStart`=0; `oFrameStart`=0.
- **Leaving reset:** `rst` is released synchronously to the design. The first `tick` occurs CLK_DIV cycles after the first active edge.
- **No start-up strobe:** there is no `oFrameStart` or `oLineStart` pulse for the reset-time (0,0) position. The first `oFrameStart` follows the first full frame.
- **Latency:** HS/VS/`oDE`/RGB lag `oCtrH`/`oCtrV` by exactly 1 `clk`. The pixel source must present `rgb` for (h,v) while the counters show (h,v).
- **Period:** line = H_TOTAL*CLK_DIV `clk`; frame = H_TOTAL*V_TOTAL*CLK_DIV `clk`. Defaults: 1600 and 840000.
- **Simultaneous wraps:** when an h wrap and a v wrap occur together, `oLineStart` and `oFrameStart` pulse in the same cycle.
- **Reset mid-frame:** all state returns immediately to reset values, with no pulse on either strobe. Counting resumes from (0,0).
- **Pulse width:** sync pulse widths are exact multiples of CLK_DIV `clk`. No glitches, because all outputs are registered.

## Test plan
1. **Reset values:** hold `rst`=0 for 50 clk with `rgb`=3'b100 → all outputs at reset values (HS=VS=1, RGB=0, `oDE`=0). Assert `rst`=0 mid-line at h=300 → counters read 0 in the same cycle.
2. **Horizontal timing (defaults):** HS falls 1 clk after `oCtrH` becomes 656 and rises 192 clk later (h=752). `oDE` is high for 1280 clk per visible line.
3. **Colour gating:** `rgb`=3'b100 → RED=1, GREEN=BLUE=0 while `oDE`=1. RED=0 for h>=640 and for v>=480.
4. **Frame timing (defaults):** VS is low for exactly 2 lines (3200 clk) starting at v=490. Consecutive `oFrameStart` pulses are 840000 clk apart. Each `oFrameStart` coincides with an `oLineStart`.
5. **Alternate parameters:** H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, VS_POL=1, COLOR_W=4, CLK_DIV=1 → line = 8 clk, frame = 48 clk. HS is high on h=5,6 and VS is high on v=4. A 12-bit `rgb` value passes through unchanged when active.
